// File: rtl/ibex_alu_sched_if.sv
// Request/grant and intermediate-value bundle between the EX stage, multdiv unit and the
// shared-adder scheduler (ibex_alu_sched).
interface ibex_alu_sched_if #(
    parameter int ImdW = 32
);
    logic                 alu_req_i;
    logic                 alu_multicycle_i;
    logic                 md_req_i;
    logic [1:0]           imd_val_we_i;
    logic [1:0][ImdW-1:0] imd_val_d_i;
    logic                 alu_gnt_o;
    logic                 md_gnt_o;
    logic                 instr_first_cycle_o;
    logic                 alu_done_o;
    logic [1:0][ImdW-1:0] imd_val_q_o;
    logic                 busy_o;
    logic [15:0]          stall_cnt_o;
    logic [1:0]           dbg_state_o;

    // Handshake: alu_req_i is held until the single-cycle alu_done_o pulse; md_req_i/md_gnt_o are per cycle.
    modport master (
        output alu_req_i, alu_multicycle_i, md_req_i, imd_val_we_i, imd_val_d_i,
        input  alu_gnt_o, md_gnt_o, instr_first_cycle_o, alu_done_o, imd_val_q_o,
               busy_o, stall_cnt_o, dbg_state_o
    );

    modport slave (
        input  alu_req_i, alu_multicycle_i, md_req_i, imd_val_we_i, imd_val_d_i,
        output alu_gnt_o, md_gnt_o, instr_first_cycle_o, alu_done_o, imd_val_q_o,
               busy_o, stall_cnt_o, dbg_state_o
    );
endinterface

// File: rtl/ibex_alu_sched.sv
// Arbiter for the adder shared by the ALU and the multdiv unit, plus the ALU intermediate registers.
// Optional feature macro: IBEX_ALU_SCHED_PERF_CNT_EN enables the saturating contention stall counter.
module ibex_alu_sched #(
    parameter int MaxMdRun = 8,
    parameter int ImdW     = 32
) (
    input logic             clk_i,
    input logic             rst_i,
    ibex_alu_sched_if.slave bus
);
    localparam int RunW = $clog2(MaxMdRun + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ALU1 = 2'd1,
        S_ALU2 = 2'd2,
        S_MD   = 2'd3
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [RunW-1:0]      r_run;
    logic [RunW-1:0]      w_run_next;
    logic                 r_last_md;
    logic                 w_last_md_next;
    logic [1:0][ImdW-1:0] r_imd;
    logic                 w_alu_gnt;
    logic                 w_md_gnt;
    logic                 w_first;
    logic                 w_done;
    logic                 w_take_alu;
    logic                 w_run_max;

    assign w_run_max = (r_run == RunW'(MaxMdRun));

    always_comb begin
        w_alu_gnt      = 1'b0;
        w_md_gnt       = 1'b0;
        w_first        = 1'b0;
        w_done         = 1'b0;
        w_take_alu     = 1'b0;
        w_state_next   = r_state;
        w_run_next     = r_run;
        w_last_md_next = r_last_md;

        case (r_state)
            S_IDLE: begin
                // On contention the side not granted last wins.
                if (bus.alu_req_i && (!bus.md_req_i || r_last_md)) begin
                    w_take_alu = 1'b1;
                end else if (bus.md_req_i) begin
                    w_md_gnt       = 1'b1;
                    w_state_next   = S_MD;
                    w_run_next     = RunW'(1);
                    w_last_md_next = 1'b1;
                end
            end
            S_ALU1: begin
                w_alu_gnt    = 1'b1;
                w_state_next = S_ALU2;
            end
            S_ALU2: begin
                w_alu_gnt    = 1'b1;
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            S_MD: begin
                if (!bus.md_req_i) begin
                    w_state_next = S_IDLE;
                    w_run_next   = '0;
                end else if (bus.alu_req_i && w_run_max) begin
                    w_take_alu = 1'b1;
                    w_run_next = '0;
                end else begin
                    w_md_gnt = 1'b1;
                    if (!w_run_max) begin
                        w_run_next = r_run + RunW'(1);
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_take_alu) begin
            w_alu_gnt      = 1'b1;
            w_last_md_next = 1'b0;
            if (bus.alu_multicycle_i) begin
                w_first      = 1'b1;
                w_state_next = S_ALU1;
            end else begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
        end

        // Reset dominates: no grant or done pulse while it is asserted.
        if (rst_i) begin
            w_alu_gnt = 1'b0;
            w_md_gnt  = 1'b0;
            w_first   = 1'b0;
            w_done    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_run     <= '0;
            r_last_md <= 1'b0;
            r_imd     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_run     <= w_run_next;
            r_last_md <= w_last_md_next;
            for (int i = 0; i < 2; i++) begin
                if (bus.imd_val_we_i[i] && w_alu_gnt) begin
                    r_imd[i] <= bus.imd_val_d_i[i];
                end
            end
        end
    end

`ifdef IBEX_ALU_SCHED_PERF_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall <= 16'd0;
        end else if (bus.alu_req_i && !w_alu_gnt && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign bus.stall_cnt_o = r_stall;
`else
    assign bus.stall_cnt_o = 16'd0;
`endif

    assign bus.alu_gnt_o           = w_alu_gnt;
    assign bus.md_gnt_o            = w_md_gnt;
    assign bus.instr_first_cycle_o = w_first;
    assign bus.alu_done_o          = w_done;
    assign bus.imd_val_q_o         = r_imd;
    assign bus.busy_o              = (r_state != S_IDLE);
    assign bus.dbg_state_o         = r_state;
endmodule

// File: tb/tb_ibex_alu_sched.sv
// Directed self-checking bench for ibex_alu_sched with an expected-value queue for ALU completions.
module tb_ibex_alu_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    ibex_alu_sched_if #(.ImdW(32)) bus ();

    ibex_alu_sched #(.MaxMdRun(8), .ImdW(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] m_imd;
    logic [15:0] exp_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then check combinational outputs before the next rising edge.
    task automatic step(input string tag, input logic a, input logic mc, input logic m,
                        input logic [1:0] we, input logic [31:0] d1, input logic [31:0] d0,
                        input logic ea, input logic em, input logic ef, input logic ed);
        logic [63:0] exp_imd;
        @(negedge clk);
        bus.alu_req_i        = a;
        bus.alu_multicycle_i = mc;
        bus.md_req_i         = m;
        bus.imd_val_we_i     = we;
        bus.imd_val_d_i      = {d1, d0};
        #2;
        chk({tag, ".alu_gnt"}, 64'(bus.alu_gnt_o), 64'(ea));
        chk({tag, ".md_gnt"}, 64'(bus.md_gnt_o), 64'(em));
        chk({tag, ".first"}, 64'(bus.instr_first_cycle_o), 64'(ef));
        chk({tag, ".done"}, 64'(bus.alu_done_o), 64'(ed));
        if (bus.alu_done_o === 1'b1) begin
            chk({tag, ".sb_pending"}, 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_imd = exp_q.pop_front();
                chk({tag, ".sb_imd"}, bus.imd_val_q_o, exp_imd);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst                  = 1'b1;
        bus.alu_req_i        = 1'b1;
        bus.alu_multicycle_i = 1'b1;
        bus.md_req_i         = 1'b1;
        #2;
        chk({tag, ".alu_gnt"}, 64'(bus.alu_gnt_o), 64'd0);
        chk({tag, ".md_gnt"}, 64'(bus.md_gnt_o), 64'd0);
        chk({tag, ".done"}, 64'(bus.alu_done_o), 64'd0);
        @(negedge clk);
        rst                  = 1'b0;
        bus.alu_req_i        = 1'b0;
        bus.alu_multicycle_i = 1'b0;
        bus.md_req_i         = 1'b0;
        bus.imd_val_we_i     = 2'b00;
        #2;
        chk({tag, ".state"}, 64'(bus.dbg_state_o), 64'd0);
        chk({tag, ".busy"}, 64'(bus.busy_o), 64'd0);
        chk({tag, ".imd"}, bus.imd_val_q_o, 64'd0);
        chk({tag, ".stall"}, 64'(bus.stall_cnt_o), 64'd0);
    endtask

    initial begin
        bus.alu_req_i        = 1'b0;
        bus.alu_multicycle_i = 1'b0;
        bus.md_req_i         = 1'b0;
        bus.imd_val_we_i     = 2'b00;
        bus.imd_val_d_i      = '0;
`ifdef IBEX_ALU_SCHED_PERF_CNT_EN
        exp_stall = 16'd8;
`else
        exp_stall = 16'd0;
`endif

        do_reset("rst0");
        m_imd = 64'd0;

        // Single-cycle op: grant and done in the request cycle.
        exp_q.push_back(m_imd);
        step("single", 1, 0, 0, 2'b01, 32'h0, 32'hAAAA_0001, 1, 0, 0, 1);
        m_imd[31:0] = 32'hAAAA_0001;
        step("nogrant_wr", 0, 0, 0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        chk("single.busy", 64'(bus.busy_o), 64'd0);
        chk("single.imd", bus.imd_val_q_o, m_imd);

        // Multicycle op with both intermediate writes; multdiv requests are ignored in ALU1/ALU2.
        exp_q.push_back({32'h1234_5678, 32'hDEAD_BEEF});
        step("mc.c0", 1, 1, 0, 2'b11, 32'h1234_5678, 32'hDEAD_BEEF, 1, 0, 1, 0);
        chk("dropped_wr.imd", bus.imd_val_q_o, m_imd);
        m_imd = {32'h1234_5678, 32'hDEAD_BEEF};
        step("mc.c1", 1, 1, 1, 2'b00, 32'h0, 32'h0, 1, 0, 0, 0);
        chk("mc.c1.imd", bus.imd_val_q_o, m_imd);
        chk("mc.c1.state", 64'(bus.dbg_state_o), 64'd1);
        chk("mc.c1.busy", 64'(bus.busy_o), 64'd1);
        step("mc.c2", 1, 1, 1, 2'b00, 32'h0, 32'h0, 1, 0, 0, 1);
        step("md.c0", 0, 0, 1, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0);
        chk("md.c0.busy", 64'(bus.busy_o), 64'd0);
        step("md.drop", 0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0);
        chk("md.drop.state", 64'(bus.dbg_state_o), 64'd3);

        // Multdiv owned the adder last, so ALU wins the tie; then ALU drops its request in ALU1.
        exp_q.push_back({m_imd[63:32], 32'h5555_0000});
        step("fair.c0", 1, 1, 1, 2'b01, 32'h0, 32'h5555_0000, 1, 0, 1, 0);
        m_imd[31:0] = 32'h5555_0000;
        step("drop.c1", 0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 0, 0, 0);
        step("drop.c2", 0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 0, 0, 1);
        step("drop.idle", 0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0);
        chk("drop.busy", 64'(bus.busy_o), 64'd0);

        // Reset in ALU1 aborts the op without a done pulse and clears the intermediates.
        step("rst.c0", 1, 1, 0, 2'b11, 32'hCAFE_0001, 32'hCAFE_0002, 1, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("rst.alu1.state", 64'(bus.dbg_state_o), 64'd1);
        chk("rst.alu1.gnt", 64'(bus.alu_gnt_o), 64'd0);
        chk("rst.alu1.done", 64'(bus.alu_done_o), 64'd0);
        @(negedge clk);
        rst                  = 1'b0;
        bus.alu_req_i        = 1'b0;
        bus.alu_multicycle_i = 1'b0;
        bus.imd_val_we_i     = 2'b00;
        #2;
        chk("rst.after.state", 64'(bus.dbg_state_o), 64'd0);
        chk("rst.after.imd", bus.imd_val_q_o, 64'd0);
        chk("rst.after.done", 64'(bus.alu_done_o), 64'd0);
        m_imd = 64'd0;

        // Both requests after reset: multdiv first, ALU the cycle after multdiv drops.
        step("both.c0", 1, 0, 1, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0);
        step("both.c1", 1, 0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0);
        exp_q.push_back(m_imd);
        step("both.c2", 1, 0, 0, 2'b00, 32'h0, 32'h0, 1, 0, 0, 1);

        // Multdiv held high: it keeps the adder for MaxMdRun cycles before the waiting ALU gets it.
        do_reset("rst1");
        for (int i = 0; i < 8; i++) begin
            step($sformatf("starve.md%0d", i), 1, 0, 1, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0);
        end
        exp_q.push_back(m_imd);
        step("starve.alu", 1, 0, 1, 2'b00, 32'h0, 32'h0, 1, 0, 0, 1);
        step("starve.after", 0, 0, 1, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0);
        chk("starve.stall", 64'(bus.stall_cnt_o), 64'(exp_stall));
        step("starve.end", 0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0);

        chk("sb.drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
